// File: rtl/hash_function_pipe_if.sv
// Valid/ready bundle for the hash pipe: key/tag in, hash/key/tag out.
// The pipe is the slave and the tuple reader / bucket logic side is the master.
interface hash_function_pipe_if #(
  parameter int KEY_W  = 64,
  parameter int HASH_W = 31,
  parameter int TAG_W  = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [KEY_W-1:0]  in_key;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [HASH_W-1:0] out_hash;
  logic [KEY_W-1:0]  out_key;
  logic [TAG_W-1:0]  out_tag;

  modport slave (
    input  in_valid, in_key, in_tag, out_ready,
    output in_ready, out_valid, out_hash, out_key, out_tag
  );

  modport master (
    output in_valid, in_key, in_tag, out_ready,
    input  in_ready, out_valid, out_hash, out_key, out_tag
  );
endinterface

// File: rtl/hash_function_pipe.sv
// Pipelined multiplicative key hash with global-stall backpressure and key/tag passthrough.
// Optional macro HASH_FUNCTION_PIPE_FOLD_EN adds an XOR fold of the upper sum bits in the add stage.
module hash_function_pipe #(
  parameter int          KEY_W      = 64,
  parameter int          HASH_W     = 31,
  parameter int          TAG_W      = 16,
  parameter int          MUL_STAGES = 2,
  parameter logic [31:0] PRIME_0    = 32'h1E698F65,
  parameter logic [31:0] PRIME_1    = 32'h24820C8D
) (
  input  logic                 clk,
  input  logic                 rst,
  hash_function_pipe_if.slave  bus,
  output logic                 busy
);
  localparam int LAT  = MUL_STAGES + 1;
  localparam int HALF = KEY_W / 2;

  logic        w_adv;
  logic [47:0] w_hi, w_lo, w_p0, w_p1, w_sum, w_fold;

  logic [LAT-1:0]    r_vld;
  logic [47:0]       r_p0  [MUL_STAGES];
  logic [47:0]       r_p1  [MUL_STAGES];
  logic [KEY_W-1:0]  r_key [LAT];
  logic [TAG_W-1:0]  r_tag [LAT];
  logic [HASH_W-1:0] r_hash;

  assign w_adv = !r_vld[LAT-1] || bus.out_ready;

  assign w_hi  = 48'(bus.in_key[KEY_W-1:HALF]);
  assign w_lo  = 48'(bus.in_key[HALF-1:0]);
  // 48-bit operands make the products wrap mod 2^48 without extra masking
  assign w_p0  = w_hi * 48'(PRIME_0);
  assign w_p1  = w_lo * 48'(PRIME_1);
  assign w_sum = r_p0[MUL_STAGES-1] + r_p1[MUL_STAGES-1];

`ifdef HASH_FUNCTION_PIPE_FOLD_EN
  assign w_fold = w_sum ^ (w_sum >> HASH_W);
`else
  assign w_fold = w_sum;
`endif

  // Bits above HASH_W are intentionally dropped in the truncating build
  logic w_unused_fold_hi;
  assign w_unused_fold_hi = |(w_fold >> HASH_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_hash <= '0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        r_p0[i] <= '0;
        r_p1[i] <= '0;
      end
      for (int i = 0; i < LAT; i++) begin
        r_key[i] <= '0;
        r_tag[i] <= '0;
      end
    end else if (w_adv) begin
      r_vld   <= {r_vld[LAT-2:0], bus.in_valid};
      r_p0[0] <= w_p0;
      r_p1[0] <= w_p1;
      for (int i = 1; i < MUL_STAGES; i++) begin
        r_p0[i] <= r_p0[i-1];
        r_p1[i] <= r_p1[i-1];
      end
      r_key[0] <= bus.in_key;
      r_tag[0] <= bus.in_tag;
      for (int i = 1; i < LAT; i++) begin
        r_key[i] <= r_key[i-1];
        r_tag[i] <= r_tag[i-1];
      end
      r_hash <= w_fold[HASH_W-1:0];
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld[LAT-1];
  assign bus.out_hash  = r_hash;
  assign bus.out_key   = r_key[LAT-1];
  assign bus.out_tag   = r_tag[LAT-1];
  assign busy          = |r_vld;
endmodule

// File: tb/tb_hash_function_pipe.sv
// Directed and randomized checks of hash_function_pipe: default build plus a KEY_W=32/HASH_W=20 instance.
module tb_hash_function_pipe;
  logic clk = 1'b0;
  logic rst;
  logic busy, busy2;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hash_function_pipe_if #(.KEY_W(64), .HASH_W(31), .TAG_W(16)) bus ();
  hash_function_pipe_if #(.KEY_W(32), .HASH_W(20), .TAG_W(8))  bus2 ();

  hash_function_pipe u_dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));
  hash_function_pipe #(.KEY_W(32), .HASH_W(20), .TAG_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .busy(busy2));

  typedef struct {
    logic [63:0] key;
    logic [15:0] tag;
    logic [30:0] hash;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [47:0] ref_hash(input logic [63:0] key, input int kw, input int hw);
    logic [63:0] mask;
    logic [47:0] hi, lo, s;
    mask = (64'd1 << (kw / 2)) - 64'd1;
    hi = 48'((key >> (kw / 2)) & mask);
    lo = 48'(key & mask);
    s  = hi * 48'h1E698F65 + lo * 48'h24820C8D;
`ifdef HASH_FUNCTION_PIPE_FOLD_EN
    s  = s ^ (s >> hw);
`endif
    return s & ((48'd1 << hw) - 48'd1);
  endfunction

  task automatic send_one(input string nm, input logic [63:0] key, input logic [15:0] tag,
                          input logic [30:0] exp);
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_key   = key;
    bus.in_tag   = tag;
    #1 chk({nm, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({nm, " latency"}, 64'(lat), 64'd3);
    chk({nm, " hash"}, 64'(bus.out_hash), 64'(exp));
    chk({nm, " key"}, bus.out_key, key);
    chk({nm, " tag"}, 64'(bus.out_tag), 64'(tag));
  endtask

  task automatic run_stream(input int n, input int stall_lo, input int stall_hi);
    logic [63:0] q[$];
    logic [63:0] k;
    logic        held_v = 1'b0;
    logic [30:0] h_hash;
    logic [63:0] h_key;
    logic [15:0] h_tag;
    int sent = 0, got = 0, cyc = 0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      if (held_v) begin
        chk("stall valid held", 64'(bus.out_valid), 64'd1);
        chk("stall hash held", 64'(bus.out_hash), 64'(h_hash));
        chk("stall key held", bus.out_key, h_key);
        chk("stall tag held", 64'(bus.out_tag), 64'(h_tag));
      end
      bus.out_ready = !(cyc >= stall_lo && cyc < stall_hi);
      bus.in_valid  = (sent < n);
      bus.in_key    = {32'(sent + 1), 32'(sent * 7 + 3)};
      bus.in_tag    = 16'(sent + 256);
      #1;
      chk("stream in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("stream unexpected output", 64'(q.size()), 64'd1);
        end else begin
          k = q.pop_front();
          chk("stream key", bus.out_key, k);
          chk("stream tag", 64'(bus.out_tag), 64'(got + 256));
          chk("stream hash", 64'(bus.out_hash), 64'(ref_hash(k, 64, 31)));
        end
        got++;
      end
      held_v = bus.out_valid && !bus.out_ready;
      h_hash = bus.out_hash;
      h_key  = bus.out_key;
      h_tag  = bus.out_tag;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(bus.in_key);
        sent++;
      end
      @(posedge clk);
      cyc++;
    end
    chk("stream count", 64'(got), 64'(n));
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic run_random(input int n);
    logic [39:0] q[$];
    logic [39:0] e;
    int sent = 0, got = 0, cyc = 0;
    while (got < n && cyc < 2000) begin
      @(negedge clk);
      bus2.out_ready = 1'($urandom_range(0, 1));
      if (!bus2.in_valid || bus2.in_ready) begin
        bus2.in_valid = (sent < n) && ($urandom_range(0, 3) != 0);
        bus2.in_key   = 32'($urandom);
        bus2.in_tag   = 8'($urandom);
      end
      #1;
      if (bus2.out_valid && bus2.out_ready) begin
        if (q.size() == 0) begin
          chk("rand unexpected output", 64'(q.size()), 64'd1);
        end else begin
          e = q.pop_front();
          chk("rand key", 64'(bus2.out_key), 64'(e[39:8]));
          chk("rand tag", 64'(bus2.out_tag), 64'(e[7:0]));
          chk("rand hash", 64'(bus2.out_hash), 64'(ref_hash(64'(e[39:8]), 32, 20)));
        end
        got++;
      end
      if (bus2.in_valid && bus2.in_ready) begin
        q.push_back({bus2.in_key, bus2.in_tag});
        sent++;
      end
      @(posedge clk);
      cyc++;
    end
    chk("rand count", 64'(got), 64'(n));
    @(negedge clk);
    bus2.in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{64'h0000_0001_0000_0001, 16'h0001, 31'h42EB9BF2};
    vecs[1] = '{64'h0000_0002_0000_0000, 16'h0002, 31'h3CD31ECA};
    vecs[2] = '{64'h0000_0000_0000_0000, 16'hFFFF, 31'h00000000};
    vecs[3] = '{64'h0000_0000_0000_0001, 16'h0A0A, 31'h24820C8D};
    vecs[4] = '{64'h0000_0003_0000_0000, 16'h1234, 31'h5B3CAE2F};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 16'h8000, 31'h3D14640E};
`ifdef HASH_FUNCTION_PIPE_FOLD_EN
    foreach (vecs[i]) vecs[i].hash = 31'(ref_hash(vecs[i].key, 64, 31));
`endif

    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.in_key = '0;  bus.in_tag = '0;  bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_key = '0; bus2.in_tag = '0; bus2.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset out_hash", 64'(bus.out_hash), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      send_one($sformatf("vec%0d", i), vecs[i].key, vecs[i].tag, vecs[i].hash);

    // back-to-back pair must emerge on consecutive cycles, in order
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_key = 64'h0000_0002_0000_0000; bus.in_tag = 16'hAA;
    @(negedge clk);
    bus.in_key = 64'h0; bus.in_tag = 16'hBB;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.out_valid; i++) @(negedge clk);
    chk("b2b first valid", 64'(bus.out_valid), 64'd1);
    chk("b2b first hash", 64'(bus.out_hash), 64'h3CD31ECA);
    chk("b2b first tag", 64'(bus.out_tag), 64'hAA);
    @(negedge clk);
    chk("b2b second valid", 64'(bus.out_valid), 64'd1);
    chk("b2b second hash", 64'(bus.out_hash), 64'd0);
    chk("b2b second tag", 64'(bus.out_tag), 64'hBB);
    @(negedge clk);
    chk("b2b drained", 64'(busy), 64'd0);

    run_stream(10, 6, 11);
    repeat (4) @(negedge clk);
    chk("stream drained busy", 64'(busy), 64'd0);

    // reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_key = 64'(i + 5) << 32; bus.in_tag = 16'(i + 1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre-reset out_valid", 64'(bus.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid reset busy", 64'(busy), 64'd0);
    chk("mid reset out_hash", 64'(bus.out_hash), 64'd0);
    chk("mid reset out_key", bus.out_key, 64'd0);
    chk("mid reset out_tag", 64'(bus.out_tag), 64'd0);
    chk("mid reset in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    send_one("post reset", vecs[0].key, 16'h00C3, vecs[0].hash);

    run_random(40);
    repeat (5) @(negedge clk);
    chk("rand drained busy", 64'(busy2), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
